// File: rtl/snoop_cache_node.sv
// snoop_cache_node: per-processor MSI snooping cache node on a 24-bit coherence bus.
// Ports: i_Clk/i_Rst_n (async active-low); processor side i_Req_valid/we/tag/data,
// o_Req_ready, o_Rsp_valid/o_Rsp_data; bus side o_Bus (issued transaction),
// i_Bus_gnt, i_MemBus (read-miss reply), i_Snoop (other nodes' transactions).
// Bus word: [23] valid, [22:21] op (RM/WM/INV/FLUSH), [20:18] tag, [17:11] data,
// [10] write-back present, [9:7] write-back tag, [6:0] write-back data.
// SNOOP_CACHE_STATS_EN adds saturating o_Hit_cnt/o_Miss_cnt lookup counters.
module snoop_cache_node #(
    parameter int N_LINES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Req_valid,
    input  logic        i_Req_we,
    input  logic [2:0]  i_Req_tag,
    input  logic [6:0]  i_Req_data,
    output logic        o_Req_ready,
    output logic        o_Rsp_valid,
    output logic [6:0]  o_Rsp_data,
    output logic [23:0] o_Bus,
    input  logic        i_Bus_gnt,
    input  logic [23:0] i_MemBus,
`ifdef SNOOP_CACHE_STATS_EN
    output logic [7:0]  o_Hit_cnt,
    output logic [7:0]  o_Miss_cnt,
`endif
    input  logic [23:0] i_Snoop
);
    localparam int IW = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam logic [1:0] LI = 2'd0, LS = 2'd1, LM = 2'd2;
    localparam logic [1:0] OP_RM = 2'd0, OP_WM = 2'd1, OP_INV = 2'd2, OP_FL = 2'd3;

    typedef enum logic [1:0] {IDLE, BUS, FILL, RESP} state_t;

    function automatic logic [IW-1:0] ix(input logic [2:0] t);
        return (N_LINES == 1) ? '0 : t[IW-1:0];
    endfunction

    state_t st, st_nx;
    logic [1:0] ln_st [N_LINES];
    logic [2:0] ln_tag [N_LINES];
    logic [6:0] ln_data [N_LINES];
    logic [1:0] eff_st [N_LINES];
    logic [N_LINES-1:0] pend, pend_eff;
    logic [2:0] req_tag;
    logic [6:0] req_data;
    logic [23:0] word;
    logic [IW-1:0] s_idx, l_idx, q_idx, p_idx;
    logic [1:0] l_st, w_op;
    logic s_hit, s_rm_m, s_kill, hit, wb, accept, flush, gnt_done;
    logic unused_bits;

    assign unused_bits = ^{i_MemBus[23:21], i_MemBus[10:0], i_Snoop[17:0]};

    assign s_idx  = ix(i_Snoop[20:18]);
    assign s_hit  = i_Snoop[23] && ln_st[s_idx] != LI && ln_tag[s_idx] == i_Snoop[20:18];
    assign s_rm_m = s_hit && i_Snoop[22:21] == OP_RM && ln_st[s_idx] == LM;
    assign s_kill = s_hit && (i_Snoop[22:21] == OP_WM || i_Snoop[22:21] == OP_INV);

    // Snoop effects are folded in combinationally so a same-cycle lookup sees them.
    always_comb begin
        eff_st   = ln_st;
        pend_eff = '0;
        p_idx    = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            eff_st[i]   = (s_idx == IW'(i) && s_rm_m) ? LS : (s_idx == IW'(i) && s_kill) ? LI : ln_st[i];
            pend_eff[i] = (s_idx == IW'(i) && s_rm_m) || (pend[i] && !(s_idx == IW'(i) && s_kill));
            if (pend_eff[i]) p_idx = IW'(i);
        end
    end

    assign l_idx       = ix(i_Req_tag);
    assign q_idx       = ix(req_tag);
    assign l_st        = eff_st[l_idx];
    assign hit         = l_st != LI && ln_tag[l_idx] == i_Req_tag;
    assign wb          = !hit && l_st == LM;
    assign w_op        = word[22:21];
    // A pending flush (including one raised this cycle) blocks new requests.
    assign o_Req_ready = i_Rst_n && st == IDLE && pend_eff == '0;
    assign accept      = o_Req_ready && i_Req_valid;
    assign flush       = st == IDLE && pend_eff != '0;
    assign gnt_done    = st == BUS && i_Bus_gnt;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) st <= IDLE;
        else st <= st_nx;
    end

    always_comb begin
        st_nx       = st;
        o_Bus       = 24'd0;
        o_Rsp_valid = 1'b0;
        o_Rsp_data  = 7'd0;
        case (st)
            IDLE: st_nx = flush ? BUS : !accept ? IDLE : (hit && (!i_Req_we || l_st == LM)) ? RESP : BUS;
            BUS: begin
                o_Bus = word;
                // A flush whose line was invalidated meanwhile is abandoned.
                st_nx = (w_op == OP_FL && !pend_eff[q_idx]) ? IDLE : !i_Bus_gnt ? BUS :
                        w_op == OP_RM ? FILL : w_op == OP_FL ? IDLE : RESP;
            end
            FILL: st_nx = RESP;
            RESP: begin
                st_nx       = IDLE;
                o_Rsp_valid = 1'b1;
                o_Rsp_data  = ln_data[q_idx];
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < N_LINES; i++) begin
                ln_st[i]   <= LI;
                ln_tag[i]  <= 3'd0;
                ln_data[i] <= 7'd0;
            end
            pend     <= '0;
            req_tag  <= 3'd0;
            req_data <= 7'd0;
            word     <= 24'd0;
        end else begin
            for (int i = 0; i < N_LINES; i++) ln_st[i] <= eff_st[i];
            pend <= pend_eff;
            if (flush) begin
                req_tag <= ln_tag[p_idx];
                word    <= {1'b1, OP_FL, ln_tag[p_idx], ln_data[p_idx], 1'b1, ln_tag[p_idx], ln_data[p_idx]};
            end else if (accept) begin
                req_tag  <= i_Req_tag;
                req_data <= i_Req_data;
                word     <= {1'b1, hit ? OP_INV : i_Req_we ? OP_WM : OP_RM, i_Req_tag,
                             i_Req_we ? i_Req_data : 7'd0, wb, wb ? {ln_tag[l_idx], ln_data[l_idx]} : 10'd0};
                if (hit && i_Req_we && l_st == LM) ln_data[l_idx] <= i_Req_data;
            end
            // Losing the line while waiting for the bus: an upgrade becomes a full
            // write miss, and any victim write-back is stale.
            if (st == BUS && w_op != OP_FL && s_kill && s_idx == q_idx) begin
                word[22:21] <= (w_op == OP_INV) ? OP_WM : w_op;
                word[10]    <= 1'b0;
            end
            if (gnt_done && w_op != OP_RM) pend[q_idx] <= 1'b0;
            if (gnt_done && (w_op == OP_WM || w_op == OP_INV)) begin
                ln_st[q_idx]   <= LM;
                ln_tag[q_idx]  <= req_tag;
                ln_data[q_idx] <= req_data;
            end
            if (st == FILL) begin
                ln_st[q_idx]   <= LS;
                ln_tag[q_idx]  <= req_tag;
                ln_data[q_idx] <= (i_MemBus[20:18] == req_tag) ? i_MemBus[17:11] : 7'd0;
                pend[q_idx]    <= 1'b0;
            end
        end
    end

`ifdef SNOOP_CACHE_STATS_EN
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Hit_cnt  <= 8'd0;
            o_Miss_cnt <= 8'd0;
        end else if (accept) begin
            if (hit) o_Hit_cnt <= o_Hit_cnt + 8'(o_Hit_cnt != 8'hFF);
            else o_Miss_cnt <= o_Miss_cnt + 8'(o_Miss_cnt != 8'hFF);
        end
    end
`endif
endmodule

// File: tb/tb_snoop_cache_node.sv
// tb_snoop_cache_node: directed scoreboard bench for snoop_cache_node (N_LINES=2).
module tb_snoop_cache_node;
    typedef struct {
        logic [6:0] d;
        int         c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, bus_gnt, req_ready, rsp_valid;
    logic [2:0]  req_tag;
    logic [6:0]  req_data, rsp_data;
    logic [23:0] bus, snoop;
    logic [23:0] mem_bus = 24'd0;
    logic [23:0] last_bus = 24'd0;
    int          bus_cnt = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        e;

    snoop_cache_node dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Req_valid(req_valid), .i_Req_we(req_we),
        .i_Req_tag(req_tag), .i_Req_data(req_data), .o_Req_ready(req_ready),
        .o_Rsp_valid(rsp_valid), .o_Rsp_data(rsp_data), .o_Bus(bus),
        .i_Bus_gnt(bus_gnt), .i_MemBus(mem_bus), .i_Snoop(snoop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Memory holds tag 5 -> 2A and tag 3 -> 33; any other tag replies with a foreign tag.
    function automatic logic [23:0] mem_reply(input logic [2:0] t);
        return (t == 3'd5) ? {3'b100, t, 7'h2A, 11'd0} :
               (t == 3'd3) ? {3'b100, t, 7'h33, 11'd0} : {3'b100, ~t, 7'h7F, 11'd0};
    endfunction

    always @(negedge clk) begin
        if (bus[23]) begin
            bus_cnt++;
            last_bus = bus;
            if (bus[22:21] == 2'd0) mem_bus = mem_reply(bus[20:18]);
        end
        if (rsp_valid) begin
            check("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.d));
                check("rsp_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sb(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) step;
        check({name, "_timeout"}, 32'(sb.size()), 32'd0);
        step;
    endtask

    task automatic req(input logic w, input logic [2:0] t, input logic [6:0] d, input logic [6:0] exp,
                       input int lat, input int nbus, input logic [23:0] exp_bus, input string name);
        int b0 = bus_cnt;
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = w;
        req_tag   = t;
        req_data  = d;
        sb.push_back('{exp, cyc + lat});
        step;
        req_valid = 1'b0;
        wait_sb(name);
        check({name, "_nbus"}, 32'(bus_cnt - b0), 32'(nbus));
        if (nbus != 0) check({name, "_bus"}, 32'(last_bus), 32'(exp_bus));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, c0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_tag = 3'd0; req_data = 7'd0;
        bus_gnt = 1'b1; snoop = 24'd0;
        step; step;
        check("rst_bus", 32'(bus), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
        rst_n = 1'b1;
        step;
        check("idle_ready", 32'(req_ready), 32'd1);

        req(1'b0, 3'd5, 7'd0, 7'h2A, 3, 1, 24'h940000, "ld5_miss");
        req(1'b0, 3'd5, 7'd0, 7'h2A, 1, 0, 24'd0, "ld5_hit");
        req(1'b1, 3'd5, 7'h11, 7'h11, 2, 1, 24'hD48800, "st5_inv");
        req(1'b0, 3'd5, 7'd0, 7'h11, 1, 0, 24'd0, "ld5_m");
        req(1'b0, 3'd3, 7'd0, 7'h33, 3, 1, 24'h8C0691, "ld3_wb");
        req(1'b1, 3'd5, 7'h11, 7'h11, 2, 1, 24'hB48800, "st5_wm");

        // Snooped RM on the M line, with a load held up behind the resulting flush.
        b0 = bus_cnt;
        check("fl_ready0", 32'(req_ready), 32'd1);
        snoop = 24'h940000; req_valid = 1'b1; req_we = 1'b0; req_tag = 3'd5; c0 = cyc;
        step;
        snoop = 24'd0;
        check("fl_ready1", 32'(req_ready), 32'd0);
        check("fl_bus", 32'(bus), 32'hF48E91);
        sb.push_back('{7'h11, c0 + 3});
        step;
        step;
        req_valid = 1'b0;
        wait_sb("fl_held_ld");
        check("fl_nbus", 32'(bus_cnt - b0), 32'd1);

        snoop = 24'h540000;
        req(1'b0, 3'd5, 7'd0, 7'h11, 1, 0, 24'd0, "ld5_ign");
        snoop = 24'd0;

        // Upgrade stalled on the bus while another node invalidates the line.
        bus_gnt = 1'b0;
        check("inv_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_tag = 3'd5; req_data = 7'h22; c0 = cyc;
        step;
        req_valid = 1'b0;
        check("inv_hold", 32'(bus), 32'hD51000);
        snoop = 24'hD40000;
        step;
        snoop = 24'd0;
        check("inv2wm", 32'(bus), 32'hB51000);
        check("inv_norsp", 32'(rsp_valid), 32'd0);
        sb.push_back('{7'h22, c0 + 3});
        bus_gnt = 1'b1;
        wait_sb("inv2wm_rsp");
        req(1'b0, 3'd5, 7'd0, 7'h22, 1, 0, 24'd0, "ld5_after");

        // Reset in the middle of a bus transaction.
        bus_gnt = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_tag = 3'd3;
        step;
        req_valid = 1'b0;
        check("mid_bus_valid", 32'(bus[23]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus", 32'(bus), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        step;
        rst_n = 1'b1; bus_gnt = 1'b1;
        step;
        req(1'b0, 3'd5, 7'd0, 7'h2A, 3, 1, 24'h940000, "ld5_postrst");
        req(1'b0, 3'd1, 7'd0, 7'h00, 3, 1, 24'h840000, "ld1_nomem");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
